// File: rtl/ahb_gpio_irq_pkg.sv
// Shared constants for the AHB-Lite GPIO slave: register word offsets and bus encodings.
package ahb_gpio_pkg;

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_DIR      = 3'd1,
        REG_IRQ_EN   = 3'd2,
        REG_IRQ_POL  = 3'd3,
        REG_IRQ_STAT = 3'd4,
        REG_SET      = 3'd5,
        REG_CLR      = 3'd6
    } reg_off_e;

    localparam int SYNC_MAX = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/ahb_gpio_irq_if.sv
// AHB-Lite slave-side bus bundle for the GPIO block; the decoder/master drives HSEL..HREADY.
interface ahb_gpio_irq_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );

endinterface

// File: rtl/ahb_gpio_irq_sync_edge.sv
// Pin input synchroniser with a trailing "prev" flop and per-pin polarity edge detection.
// A warm-up counter hides the edges produced while the chain fills after reset.
module gpio_sync_edge
    import ahb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    input  logic [GPIO_WIDTH-1:0] dir,
    input  logic [GPIO_WIDTH-1:0] pol,
    output logic [GPIO_WIDTH-1:0] sync_out,
    output logic [GPIO_WIDTH-1:0] edge_out
);

    localparam int                CNT_W     = $clog2(SYNC_MAX + 2);
    localparam logic [CNT_W-1:0]  WARM_DONE = CNT_W'(SYNC_STAGES + 1);

    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [CNT_W-1:0]      warm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_DONE) begin
            warm_cnt <= warm_cnt + CNT_W'(1);
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // prev follows every pin, so flipping dir or pol alone never fabricates an edge.
    always_comb begin
        edge_out = '0;
        if (warm_cnt == WARM_DONE) begin
            edge_out = ~dir & ((pol & sync_out & ~prev_q) | (~pol & ~sync_out & prev_q));
        end
    end

endmodule

// File: rtl/ahb_gpio_irq.sv
// Zero-wait AHB-Lite GPIO slave: direction, output data, edge interrupts with W1C status.
// Optional macro GPIO_SET_CLR_EN adds write-only SET (0x14) and CLR (0x18) registers.
module ahb_gpio_irq
    import ahb_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_gpio_irq_if.slave         bus,
    input  logic [GPIO_WIDTH-1:0] GPIOIN,
    output logic [GPIO_WIDTH-1:0] GPIOOUT,
    output logic [GPIO_WIDTH-1:0] GPIODIR,
    output logic                  GPIOIRQ
);

    logic                  valid_q;
    logic                  write_q;
    reg_off_e              addr_q;
    logic                  wr_en;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] en_q;
    logic [GPIO_WIDTH-1:0] pol_q;
    logic [GPIO_WIDTH-1:0] stat_q;
    logic [GPIO_WIDTH-1:0] stat_clr;
    logic [GPIO_WIDTH-1:0] sync_val;
    logic [GPIO_WIDTH-1:0] edge_vec;
    logic [GPIO_WIDTH-1:0] rd_val;
    logic                  unused_bus;

    assign unused_bus = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};

    gpio_sync_edge #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .gpio_in  (GPIOIN),
        .dir      (dir_q),
        .pol      (pol_q),
        .sync_out (sync_val),
        .edge_out (edge_vec)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= REG_DATA;
        end else if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
            valid_q <= 1'b1;
            write_q <= bus.HWRITE;
            addr_q  <= reg_off_e'(bus.HADDR[4:2]);
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign wr_en = valid_q && write_q;
    assign wdata = bus.HWDATA[GPIO_WIDTH-1:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_q <= '0;
            dir_q <= '0;
            en_q  <= '0;
            pol_q <= '0;
        end else if (wr_en) begin
            case (addr_q)
                REG_DATA:    out_q <= wdata;
                REG_DIR:     dir_q <= wdata;
                REG_IRQ_EN:  en_q  <= wdata;
                REG_IRQ_POL: pol_q <= wdata;
`ifdef GPIO_SET_CLR_EN
                REG_SET:     out_q <= out_q | wdata;
                REG_CLR:     out_q <= out_q & ~wdata;
`endif
                default:     ;
            endcase
        end
    end

    // A fresh edge is OR-ed in after the clear, so a coincident W1C loses.
    assign stat_clr = (wr_en && addr_q == REG_IRQ_STAT) ? wdata : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stat_q <= '0;
        end else begin
            stat_q <= (stat_q & ~stat_clr) | edge_vec;
        end
    end

    always_comb begin
        rd_val = '0;
        if (valid_q && !write_q) begin
            case (addr_q)
                REG_DATA:     rd_val = (dir_q & out_q) | (~dir_q & sync_val);
                REG_DIR:      rd_val = dir_q;
                REG_IRQ_EN:   rd_val = en_q;
                REG_IRQ_POL:  rd_val = pol_q;
                REG_IRQ_STAT: rd_val = stat_q;
                default:      rd_val = '0;
            endcase
        end
    end

    assign bus.HRDATA    = 32'(rd_val);
    assign bus.HREADYOUT = 1'b1;
    assign GPIOOUT       = out_q;
    assign GPIODIR       = dir_q;
    assign GPIOIRQ       = |(stat_q & en_q);

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed bench for ahb_gpio_irq; reads are scored by a monitor against a queue of expected data.
module tb_ahb_gpio_irq;
    import ahb_gpio_pkg::*;

    localparam int          W      = 16;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_DATA = BASE | 32'h00;
    localparam logic [31:0] A_DIR  = BASE | 32'h04;
    localparam logic [31:0] A_EN   = BASE | 32'h08;
    localparam logic [31:0] A_POL  = BASE | 32'h0C;
    localparam logic [31:0] A_STAT = BASE | 32'h10;
    localparam logic [31:0] A_SET  = BASE | 32'h14;
    localparam logic [31:0] A_CLR  = BASE | 32'h18;
    localparam logic [31:0] A_UNM  = BASE | 32'h1C;

    typedef struct {
        logic [31:0] data;
        string       name;
    } exp_t;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_dir;
    logic          gpio_irq;
    logic [31:0]   pend_wdata;
    logic          rd_pending;
    exp_t          sb_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  exp_out;

    ahb_gpio_irq_if bus();

    ahb_gpio_irq #(
        .GPIO_WIDTH  (W),
        .SYNC_STAGES (2)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus),
        .GPIOIN  (gpio_in),
        .GPIOOUT (gpio_out),
        .GPIODIR (gpio_dir),
        .GPIOIRQ (gpio_irq)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rd_pending <= 1'b0;
        else          rd_pending <= bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~bus.HWRITE;
    end

    // Monitor: every read data phase consumes one expected entry.
    always @(negedge HCLK) begin
        if (rd_pending) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL sb_underflow: HRDATA=%h with no expected entry", bus.HRDATA);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.HRDATA !== e.data) begin
                    fails++;
                    $display("[TB] FAIL %s: HRDATA=%h expected %h", e.name, bus.HRDATA, e.data);
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge HCLK);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HWDATA = pend_wdata;
        pend_wdata = wd;
    endtask

    task automatic ahb_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge HCLK);
            bus.HSEL   = 1'b0;
            bus.HTRANS = HTRANS_IDLE;
            bus.HWRITE = 1'b0;
            bus.HWDATA = pend_wdata;
            pend_wdata = '0;
        end
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] wd);
        ahb_xfer(1'b1, addr, wd);
    endtask

    task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        e.data = exp;
        e.name = name;
        sb_q.push_back(e);
        ahb_xfer(1'b0, addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        HRESETn    = 1'b0;
        gpio_in    = 16'hFFFF;
        pend_wdata = '0;
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HWDATA = '0;
        bus.HREADY = 1'b1;
        repeat (3) @(negedge HCLK);
        check_output("rst_hrdata", bus.HRDATA, 32'h0);
        check_output("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        HRESETn = 1'b1;
        ahb_idle(5);

        // Inputs held high through reset must not leave any status behind.
        check_output("rst_gpioout", {16'h0, gpio_out}, 32'h0);
        check_output("rst_gpiodir", {16'h0, gpio_dir}, 32'h0);
        check_output("rst_irq", {31'h0, gpio_irq}, 32'h0);
        ahb_read(A_DATA, 32'h0000_FFFF, "rst_data");
        ahb_read(A_DIR,  32'h0, "rst_dir");
        ahb_read(A_EN,   32'h0, "rst_en");
        ahb_read(A_POL,  32'h0, "rst_pol");
        ahb_read(A_STAT, 32'h0, "rst_stat");
        ahb_read(A_UNM,  32'h0, "rst_unmapped");
        ahb_idle(2);

        // Direction and data mix; upper input byte FF->12 falls on bits 15..8 giving ED00.
        ahb_write(A_DIR, 32'h0000_00FF);
        ahb_read(A_DIR, 32'h0000_00FF, "dir_b2b");
        ahb_write(A_DATA, 32'hFFFF_A55A);
        ahb_write(A_UNM, 32'hFFFF_FFFF);
        ahb_idle(1);
        gpio_in = 16'h1234;
        ahb_idle(4);
        check_output("gpioout", {16'h0, gpio_out}, 32'h0000_A55A);
        check_output("gpiodir", {16'h0, gpio_dir}, 32'h0000_00FF);
        ahb_read(A_DATA, 32'h0000_125A, "data_mix");
        ahb_read(A_DIR,  32'h0000_00FF, "dir_after_unm");
        ahb_read(A_STAT, 32'h0000_ED00, "stat_fall_upper");
        ahb_write(A_STAT, 32'h0000_FFFF);
        ahb_read(A_STAT, 32'h0, "stat_w1c_all");
        ahb_idle(2);
        check_output("irq_none_en", {31'h0, gpio_irq}, 32'h0);

        // Rising edge on pin 8 with precise three-edge latency.
        ahb_write(A_EN, 32'h0000_0100);
        ahb_write(A_POL, 32'h0000_0100);
        ahb_idle(3);
        gpio_in = 16'h1334;
        repeat (2) @(negedge HCLK);
        check_output("irq_lat2", {31'h0, gpio_irq}, 32'h0);
        @(negedge HCLK);
        check_output("irq_lat3", {31'h0, gpio_irq}, 32'h1);
        ahb_read(A_STAT, 32'h0000_0100, "stat_rise8");
        ahb_write(A_STAT, 32'h0000_0100);
        ahb_read(A_STAT, 32'h0, "stat_w1c8");
        ahb_idle(1);
        check_output("irq_cleared8", {31'h0, gpio_irq}, 32'h0);

        // Falling edge on pin 9 while disabled, then enable it.
        gpio_in = 16'h1134;
        ahb_idle(4);
        ahb_read(A_STAT, 32'h0000_0200, "stat_fall9");
        ahb_idle(1);
        check_output("irq_masked9", {31'h0, gpio_irq}, 32'h0);
        ahb_write(A_EN, 32'h0000_0200);
        ahb_idle(2);
        check_output("irq_en9", {31'h0, gpio_irq}, 32'h1);
        ahb_write(A_STAT, 32'h0000_0200);
        ahb_write(A_EN, 32'h0000_0100);
        ahb_idle(2);
        check_output("irq_cleared9", {31'h0, gpio_irq}, 32'h0);

        // Falling pin 8 is ignored under rising polarity; then W1C lands with a new rise.
        gpio_in = 16'h1034;
        ahb_idle(4);
        ahb_read(A_STAT, 32'h0, "stat_no_fall8");
        ahb_idle(1);
        gpio_in = 16'h1134;
        ahb_write(A_STAT, 32'h0000_0100);
        ahb_idle(2);
        ahb_read(A_STAT, 32'h0000_0100, "stat_set_wins");
        ahb_idle(1);
        check_output("irq_set_wins", {31'h0, gpio_irq}, 32'h1);

        // Reset asserted inside a write data phase discards the write.
        ahb_write(A_DATA, 32'h0000_FFFF);
        @(posedge HCLK);
        #2;
        HRESETn    = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        pend_wdata = '0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        ahb_idle(5);
        check_output("mid_rst_gpioout", {16'h0, gpio_out}, 32'h0);
        check_output("mid_rst_gpiodir", {16'h0, gpio_dir}, 32'h0);
        check_output("mid_rst_irq", {31'h0, gpio_irq}, 32'h0);
        ahb_read(A_STAT, 32'h0, "mid_rst_stat");
        ahb_read(A_DATA, 32'h0000_1134, "mid_rst_data");
        ahb_read(A_EN,   32'h0, "mid_rst_en");
        ahb_idle(2);

        // SET/CLR registers exist only with the optional macro.
        ahb_write(A_DIR, 32'h0000_FFFF);
        ahb_write(A_DATA, 32'h0000_00F0);
        ahb_write(A_SET, 32'h0000_0F00);
        ahb_write(A_CLR, 32'h0000_0030);
        ahb_idle(2);
`ifdef GPIO_SET_CLR_EN
        exp_out = 16'h0FC0;
`else
        exp_out = 16'h00F0;
`endif
        check_output("setclr_gpioout", {16'h0, gpio_out}, {16'h0, exp_out});
        ahb_read(A_DATA, {16'h0, exp_out}, "setclr_data");
        ahb_read(A_SET, 32'h0, "set_reads0");
        ahb_read(A_CLR, 32'h0, "clr_reads0");
        ahb_read(A_STAT, 32'h0, "dir_change_no_stat");
        ahb_idle(3);

        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL sb_leftover: %0d entries remain expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
